uart_rx_fifo: RTL and testbench

Serial receive front-end for the SoC's console UART: oversamples the asynchronous `pin_2` line at the system clock, deframes 8N1 characters and queues them in a small FIFO with a valid/ready output. It sits between the board RX pin and the SoC's UART register bank. It is the receive counterpart of the TX path that drives `pin_1`, so bit timing matches the bench serial monitor: 140 clocks per bit at 16 MHz.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_sync_fifo.sv | 64 ++++++
 rtl/uart_rx_fifo.sv | 112 +++++++++++
 tb/tb_uart_rx_fifo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared 8N1 UART definitions for the console RX path (and the future TX block).
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam int unsigned STOP_BITS            = 1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 140;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Single-clock FIFO with registered head data, occupancy count and drop-on-full overrun flag.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overrun_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             full, empty, do_push, do_pop;

    always_comb begin
        full      = (level_q == LW'(DEPTH));
        empty     = (level_q == '0);
        do_pop    = pop_i && !empty;
        do_push   = push_i && (!full || do_pop);
        overrun_o = push_i && full && !pop_i;
        rd_ptr_d  = rd_ptr_q + AW'(do_pop);
        level_d   = level_q + LW'(do_push) - LW'(do_pop);
        // New head comes straight from the push when it lands in the slot being read next.
        data_d    = (do_push && (wr_ptr_q == rd_ptr_d)) ? data_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + AW'(do_push);
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            if (level_d != '0) begin
                data_q <= data_d;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = (level_q != '0);
    assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Console UART receiver: synchronizes rx, deframes 8N1 characters and queues them in a FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        frame_err,
    output logic                        overrun
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t            state_q;
    logic [1:0]           sync_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 rxs, tick_done, stop_sample, push;

    assign rxs       = sync_q[1];
    assign tick_done = (tick_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            sync_q <= {sync_q[0], rx};
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        tick_q  <= TICK_HALF;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!tick_done) begin
                        tick_q <= tick_q - 1'b1;
                    end else if (!rxs) begin
                        tick_q  <= TICK_FULL;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DATA: begin
                    if (!tick_done) begin
                        tick_q <= tick_q - 1'b1;
                    end else begin
                        shreg_q <= {rxs, shreg_q[DATA_BITS-1:1]};
                        tick_q  <= TICK_FULL;
                        if (bit_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (!tick_done) begin
                        tick_q <= tick_q - 1'b1;
                    end else begin
                        state_q <= rxs ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (rxs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Push and frame_err decode registered state only, so both land in the stop-sample cycle.
    assign stop_sample = (state_q == STOP) && tick_done;
    assign push        = stop_sample && rxs;
    assign frame_err   = stop_sample && !rxs;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_i    (push),
        .data_i    (shreg_q),
        .pop_i     (rx_ready),
        .data_o    (rx_data),
        .valid_o   (rx_valid),
        .level_o   (level),
        .overrun_o (overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: serial stimulus in, popped bytes compared against a queue.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 140;
    localparam int unsigned DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] level;
    logic       frame_err;
    logic       overrun;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .level     (level),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc = 0;
    int unsigned rise_cyc = 0;
    int unsigned valid_cyc = 0;
    int unsigned fe_cnt = 0;
    int unsigned ov_cnt = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  exp_b;
    logic [7:0]  exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int unsigned stop_len);
        start_cyc = cyc;
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_v;
        tick(CPB * stop_len);
        rx = 1'b1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && !(level == 5'd0 && exp_q.size() == 0); i++) tick(1);
        check_eq("drain_level", level, 0);
        check_eq("drain_sb", exp_q.size(), 0);
    endtask

    // Output monitor: scoreboard pops on handshake, plus pulse and valid-cycle bookkeeping.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid && !valid_prev) rise_cyc = cyc;
            if (rx_valid) valid_cyc++;
            if (rx_valid && rx_ready) begin
                check_eq("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check_eq("rx_data", rx_data, exp_b);
                end
            end
        end
        valid_prev = rx_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        int unsigned fe0, ov0, v0, lat;
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_eq("rst_valid", rx_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_data", rx_data, 0);
        check_eq("rst_ferr", frame_err, 0);
        check_eq("rst_ovr", overrun, 0);

        // Two back-to-back bytes with the consumer always ready
        rx_ready = 1'b1;
        tick(10);
        fe0 = fe_cnt; ov0 = ov_cnt;
        v0 = valid_cyc;
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1);
        lat = rise_cyc - start_cyc;
        check_eq("latency", lat, (lat >= 1332 && lat <= 1334) ? lat : 1333);
        check_eq("valid_width_55", valid_cyc - v0, 1);
        v0 = valid_cyc;
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1);
        check_eq("valid_width_A3", valid_cyc - v0, 1);
        wait_drain();
        check_eq("t1_ferr", fe_cnt - fe0, 0);
        check_eq("t1_ovr", ov_cnt - ov0, 0);

        // Short low glitch on an idle line
        v0 = valid_cyc;
        rx = 1'b0;
        tick(30);
        rx = 1'b1;
        tick(CPB);
        check_eq("glitch_level", level, 0);
        check_eq("glitch_valid", valid_cyc - v0, 0);

        // Stop bit low, line held low, then a clean byte
        fe0 = fe_cnt;
        send_frame(8'h7E, 1'b0, 3);
        check_eq("ferr_pulse", fe_cnt - fe0, 1);
        check_eq("ferr_level", level, 0);
        tick(CPB);
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 1);
        wait_drain();

        // Fill past full with the consumer stalled
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1);
        end
        check_eq("full_level", level, 16);
        check_eq("ovr_pulse", ov_cnt - ov0, 1);
        rx_ready = 1'b1;
        wait_drain();

        // Full FIFO with a pop landing exactly on the 17th byte's stop sample
        rx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'h20 + 8'(i));
            send_frame(8'h20 + 8'(i), 1'b1, 1);
        end
        check_eq("refill_level", level, 16);
        ov0 = ov_cnt;
        exp_q.push_back(8'h10);
        fork
            send_frame(8'h10, 1'b1, 1);
            begin
                tick(CPB / 2 + 9 * CPB + 2);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                check_eq("pushpop_level", level, 16);
            end
        join
        check_eq("pushpop_ovr", ov_cnt - ov0, 0);
        rx_ready = 1'b1;
        wait_drain();

        // Reset in the middle of a frame with one byte already queued
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1);
        tick(5);
        check_eq("pre_rst_level", level, 1);
        fork
            send_frame(8'h99, 1'b1, 1);
            begin
                tick(1150);
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                check_eq("midrst_level", level, 0);
                check_eq("midrst_valid", rx_valid, 0);
            end
        join
        tick(300);
        rx_ready = 1'b1;
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1, 1);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
